// File: rtl/tacky_pkg.sv
// Shared tacky ISA definitions: opcodes, field widths, word builders and the
// encoder FSM state encoding.
package tacky_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned HALF_W = 8;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 11;
  localparam int unsigned REG_HI = 10;
  localparam int unsigned REG_LO = 8;

  localparam logic [OP_W-1:0] OP_A2R  = 5'b00000;
  localparam logic [OP_W-1:0] OP_LI   = 5'b00011;
  localparam logic [OP_W-1:0] OP_LF   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b01000;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01010;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b01100;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01111;
  // Remaining unnamed 10xxx codes decode as immediate-format ops.
  localparam logic [OP_W-1:0] OP_PRE  = 5'b10001;
  localparam logic [OP_W-1:0] OP_JP8  = 5'b10010;
  localparam logic [OP_W-1:0] OP_SYS  = 5'b10011;
  localparam logic [OP_W-1:0] OP_CF8  = 5'b10100;
  localparam logic [OP_W-1:0] OP_CI8  = 5'b10101;
  localparam logic [OP_W-1:0] OP_JNZ8 = 5'b10110;
  localparam logic [OP_W-1:0] OP_JZ8  = 5'b10111;

  localparam logic [HALF_W-1:0] PAD_HALF = {OP_A2R, REG_W'(0)};
  localparam logic [WORD_W-1:0] SYS_WORD = {OP_SYS, 11'b0};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EMIT_PAD  = 3'd1,
    EMIT_PRE  = 3'd2,
    EMIT_MAIN = 3'd3,
    EMIT_LIT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } req_t;

  function automatic logic is_lit(input logic [OP_W-1:0] op);
    return (op == OP_LI) || (op == OP_LF);
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == OP_PRE) || (op[4:3] == 2'b11);
  endfunction

  function automatic logic is_slot(input logic [OP_W-1:0] op);
    return !op[4] && !is_lit(op);
  endfunction

  function automatic logic is_imm(input logic [OP_W-1:0] op);
    return (op[4:3] == 2'b10) && (op != OP_PRE) && (op != OP_SYS);
  endfunction

  function automatic logic [WORD_W-1:0] pre_word(input logic [HALF_W-1:0] hi);
    return {OP_PRE, REG_W'(0), hi};
  endfunction

  function automatic logic [WORD_W-1:0] main_word(input req_t r);
    if (r.op == OP_SYS) return SYS_WORD;
    if (is_lit(r.op))   return {r.op, r.rd, HALF_W'(0)};
    return {r.op, r.rd, r.imm[HALF_W-1:0]};
  endfunction

endpackage

// File: rtl/tacky_encoder_if.sv
// Request/flush input side and encoded-word output side of the tacky encoder.
interface tacky_encoder_if;
  import tacky_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_reg;
  logic [IMM_W-1:0]  in_imm;
  logic              flush;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    output in_valid, in_op, in_reg, in_imm, flush, out_ready,
    input  in_ready, out_word, out_valid, err
  );

  modport slave (
    input  in_valid, in_op, in_reg, in_imm, flush, out_ready,
    output in_ready, out_word, out_valid, err
  );
endinterface

// File: rtl/tacky_out_reg.sv
// Single-entry valid/ready output register; word holds while not consumed.
module tacky_out_reg
  import tacky_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              ready,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              free_c
);

  // Loads are only issued while free, so a load always wins over a drain.
  assign free_c = !valid || ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tacky_encoder.sv
// Packs decoded tacky ops into 16-bit instruction words: pairs register ops,
// inserts pad halves, prefix words and literal words as needed.
module tacky_encoder
  import tacky_pkg::*;
#(
  parameter bit PRE_TRACK = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  tacky_encoder_if.slave bus
);

  state_t              state, state_n;
  req_t                req_q, req_n, req_in, cur;
  logic [HALF_W-1:0]   pend_q, pend_n;
  logic                pend_v_q, pend_v_n;
  logic [HALF_W-1:0]   shadow_q, shadow_n;
  logic                shadow_v_q, shadow_v_n;
  logic                err_q, err_n;
  logic                load_c;
  logic [WORD_W-1:0]   load_word;
  logic                free_c;
  logic                accept;
  logic                consumed;
  logic                body_c;
  logic                cur_pre;

  function automatic logic need_pre(input logic [HALF_W-1:0] hi,
                                    input logic [HALF_W-1:0] sh,
                                    input logic              sh_v);
    return !PRE_TRACK || !sh_v || (hi != sh);
  endfunction

  tacky_out_reg u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (load_c),
    .data   (load_word),
    .ready  (bus.out_ready),
    .word   (bus.out_word),
    .valid  (bus.out_valid),
    .free_c (free_c)
  );

  assign req_in       = '{op: bus.in_op, rd: bus.in_reg, imm: bus.in_imm};
  assign bus.in_ready = (state == IDLE) && free_c;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consumed     = bus.out_valid && bus.out_ready;
  assign bus.err      = err_q;

  // State is the kind of word currently held in the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_q      <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      shadow_q   <= '0;
      shadow_v_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      req_q      <= req_n;
      pend_q     <= pend_n;
      pend_v_q   <= pend_v_n;
      shadow_q   <= shadow_n;
      shadow_v_q <= shadow_v_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    req_n      = req_q;
    pend_n     = pend_q;
    pend_v_n   = pend_v_q;
    shadow_n   = shadow_q;
    shadow_v_n = shadow_v_q;
    err_n      = 1'b0;
    load_c     = 1'b0;
    load_word  = '0;
    body_c     = 1'b0;
    cur        = (state == IDLE) ? req_in : req_q;
    cur_pre    = is_imm(cur.op) && need_pre(cur.imm[IMM_W-1:HALF_W], shadow_q, shadow_v_q);

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_illegal(req_in.op)) begin
            err_n = 1'b1;
          end else if (is_slot(req_in.op)) begin
            if (pend_v_q) begin
              load_c    = 1'b1;
              load_word = {pend_q, req_in.op, req_in.rd};
              pend_v_n  = 1'b0;
            end else begin
              pend_n   = {req_in.op, req_in.rd};
              pend_v_n = 1'b1;
            end
          end else begin
            req_n = req_in;
            if (pend_v_q) begin
              load_c    = 1'b1;
              load_word = {pend_q, PAD_HALF};
              pend_v_n  = 1'b0;
              state_n   = EMIT_PAD;
            end else begin
              body_c = 1'b1;
            end
          end
        end else if (bus.flush && pend_v_q && free_c) begin
          load_c    = 1'b1;
          load_word = {pend_q, PAD_HALF};
          pend_v_n  = 1'b0;
        end
      end
      EMIT_PAD: begin
        if (consumed) body_c = 1'b1;
      end
      EMIT_PRE: begin
        if (consumed) begin
          load_c    = 1'b1;
          load_word = main_word(req_q);
          state_n   = EMIT_MAIN;
        end
      end
      EMIT_MAIN: begin
        if (consumed) begin
          if (is_lit(req_q.op)) begin
            load_c    = 1'b1;
            load_word = req_q.imm;
            state_n   = EMIT_LIT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      EMIT_LIT: begin
        if (consumed) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Prefix (when required) or main word of a non-slot op.
    if (body_c) begin
      load_c = 1'b1;
      if (cur_pre) begin
        load_word  = pre_word(cur.imm[IMM_W-1:HALF_W]);
        shadow_n   = cur.imm[IMM_W-1:HALF_W];
        shadow_v_n = 1'b1;
        state_n    = EMIT_PRE;
      end else begin
        load_word = main_word(cur);
        state_n   = EMIT_MAIN;
      end
    end
  end

endmodule

// File: doc/tacky_encoder.md
TACKY_ENCODER -- requirements
Module: tacky_encoder

Interface
REQ-001 Parameter: PRE_TRACK, default 1, meaning 1 = suppress redundant pre words by tracking the last emitted prefix, 0 = emit pre before every immediate op.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  op request present.
REQ-005 in_ready  output  1  request accepted on a cycle where in_valid=1 and in_ready=1.
REQ-006 in_op  input  5  opcode, same encoding as the processor decoder.
REQ-007 in_reg  input  3  register field.
REQ-008 in_imm  input  16  immediate or literal; ignored for register-only ops.
REQ-009 flush  input  1  level request to emit a pending half-word.
REQ-010 out_word  output  16  encoded instruction word.
REQ-011 out_valid  output  1  out_word valid.
REQ-012 out_ready  input  1  sink consumes out_word when out_valid=1 and out_ready=1.
REQ-013 err  output  1  one-cycle pulse on an illegal opcode.

Function
REQ-014 Formats: pair word = {op1[15:11], reg1[10:8], op2[7:3], reg2[2:0]}; immediate word = {op[15:11], reg[10:8], imm[7:0]}; pre word = {5'b10001, 3'b000, imm[15:8]}; sys word = {5'b10011, 11'b0}; pad half = 8'h00 (a2r r0).
REQ-015 Phase-1 ops (in_op < 5'b10000, excluding li/lf), slot rule: with no pending half, store {op,reg} as pending; with a pending half, emit {pending, op, reg} and clear pending.
REQ-016 li/lf: if a half is pending, first emit {pending, pad}; then emit {op, reg, 8'h00}, then emit the literal word in_imm.
REQ-017 jp8, jnz8, jz8, cf8, ci8: if a half is pending, first emit {pending, pad}.
REQ-018 Same ops, pre rule: emit a pre word when PRE_TRACK=0, or the prefix shadow is invalid, or in_imm[15:8] != shadow; then emit the immediate word.
REQ-019 Each pre word loads the shadow and marks it valid.
REQ-020 sys: emit {pending, pad} if a half is pending, then the sys word.
REQ-021 in_op = 5'b10001 (pre) or 5'b11000-5'b11111: consume the request, pulse err for one cycle, leave state, pending and shadow unchanged, emit nothing.
REQ-022 FSM states IDLE, EMIT_PAD, EMIT_PRE, EMIT_MAIN, EMIT_LIT; it advances one state per consumed output word.
REQ-023 Transitions: IDLE -> EMIT_PAD (pending and non-slot op), else EMIT_PRE or EMIT_MAIN; EMIT_PAD -> EMIT_PRE/EMIT_MAIN; EMIT_PRE -> EMIT_MAIN; EMIT_MAIN -> EMIT_LIT (li/lf) or IDLE; EMIT_LIT -> IDLE.
REQ-024 in_ready = 1 only in IDLE with the output register empty or being consumed that cycle; the accepted op is latched internally.
REQ-025 Latency: the first word of an accepted request is on out_valid the cycle after acceptance.
REQ-026 While out_valid=1 and out_ready=0, out_word SHALL hold stable.
REQ-027 flush is honoured only in IDLE with in_valid=0 and a half pending: emit {pending, pad}; with nothing pending, flush is a no-op.
REQ-028 When in_valid and flush are both high, the request is processed and flush is ignored that cycle.

Reset
REQ-029 Asserting reset, including mid-sequence, SHALL immediately clear out_valid and err, drop any partial sequence, empty pending, invalidate the shadow and return to IDLE.
REQ-030 out_word SHALL reset to 16'h0000.

Structure
REQ-031 Opcode constants, field ranges, pad byte and FSM state encoding live in shared package tacky_pkg, also used by the processor.
REQ-032 One sub-module, tacky_out_reg: a single-entry valid/ready output register.

Verification
REQ-033 add r2 then mul r3 -> single word 16'h4253; no output after the first op alone.
REQ-034 not r1 then ci8 r4 imm 16'h1234 -> 16'h6100, 16'h8812, 16'hAC34; then ci8 r4 imm 16'h1299 -> only 16'hAC99.
REQ-035 li r5 imm 16'hBEEF with nothing pending -> 16'h1D00 then 16'hBEEF; out_ready low for 3 cycles before the second word -> 16'hBEEF held, in_ready=0.
REQ-036 Reset pulsed during EMIT_PRE, then jp8 imm 16'h1200 -> out_valid=0 after reset; then 16'h8812 and 16'h9000.
REQ-037 in_op 5'b11000 -> err high exactly one cycle, no output; then or r7 followed by sys -> 16'h7F00, 16'h9800.
REQ-038 or r7 then flush with in_valid=0 -> 16'h7F00; flush again -> no output; repeat with PRE_TRACK=0 and jz8 16'h0005 twice -> pre word 16'h8800 before each 16'hB805.
